// File: rtl/sdram_audio_fetch_if.sv
// rtl/sdram_audio_fetch_if.sv - read-port bus between the audio fetcher and the SDRAM arbiter
interface sdram_audio_fetch_if;
    logic [25:0] addr_out;
    logic        read_out;
    logic [15:0] readdata_in;
    logic        ack_in;

    modport master (output addr_out, read_out, input readdata_in, ack_in);
    modport slave  (input addr_out, read_out, output readdata_in, ack_in);
endinterface

// File: rtl/sdram_audio_fetch.sv
// rtl/sdram_audio_fetch.sv - streams PCM words from an SDRAM region into a sample FIFO, one pop per tick
// Optional feature macro: AUDIO_FETCH_LOOP_EN (wrap to the region start instead of stopping with done)
module sdram_audio_fetch #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [25:0] BASE_ADDR  = 26'h0,
    parameter int          SPAN_LOG2  = 24
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          restart,
    sdram_audio_fetch_if.master           bus,
    input  logic                          sample_tick,
    output logic [15:0]                   sample_out,
    output logic                          sample_valid,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t                state, state_next;
    logic [25:0]           addr;
    logic                  discard;
    logic [15:0]           mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           level;
    logic                  ack_req, push, pop;
    logic [SPAN_LOG2-1:0]  offset_next;
    logic [25:0]           addr_next;

    assign ack_req     = (state == REQ) && bus.ack_in;
    assign push        = ack_req && !discard && !restart;
    assign pop         = sample_tick && (level != '0) && !restart;
    // BASE_ADDR is span-aligned, so the offset wraps to the region start on its own
    assign offset_next = addr[SPAN_LOG2-1:0] + SPAN_LOG2'(1);
    assign addr_next   = BASE_ADDR | 26'(offset_next);
    assign fifo_level  = level;
    assign bus.addr_out = addr;

    always_comb begin
        state_next   = state;
        bus.read_out = 1'b0;
        unique case (state)
            IDLE: if (enable && (level < DEPTH_L) && !restart && !done) state_next = REQ;
            REQ: begin
                bus.read_out = 1'b1;
                if (bus.ack_in) state_next = GAP;
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            state        <= IDLE;
            addr         <= BASE_ADDR;
            discard      <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_next;
            sample_valid <= pop;
            if (pop) begin
                sample_out <= mem[rd_ptr];
                rd_ptr     <= rd_ptr + PW'(1);
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (push && !pop)      level <= level + (PW+1)'(1);
            else if (pop && !push) level <= level - (PW+1)'(1);
            if (sample_tick && (level == '0)) underrun <= 1'b1;
            // addr must stay stable while the request is held, so a mid-request restart is deferred to the ack
            if (ack_req) begin
                discard <= 1'b0;
                addr    <= (restart || discard) ? BASE_ADDR : addr_next;
            end else if (restart && state == REQ) begin
                discard <= 1'b1;
            end
            if (restart) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                underrun <= 1'b0;
                if (state != REQ) addr <= BASE_ADDR;
            end
        end
    end

    always_ff @(posedge clk50) begin
        if (push) mem[wr_ptr] <= bus.readdata_in;
    end

`ifdef AUDIO_FETCH_LOOP_EN
    assign done = 1'b0;
`else
    logic done_r;
    always_ff @(posedge clk50) begin
        if (reset || restart)                      done_r <= 1'b0;
        else if (push && (&addr[SPAN_LOG2-1:0]))  done_r <= 1'b1;
    end
    assign done = done_r;
`endif
endmodule

// File: tb/tb_sdram_audio_fetch.sv
// tb/tb_sdram_audio_fetch.sv - scoreboard bench for sdram_audio_fetch with a queue-based reference model
module tb_sdram_audio_fetch;
    localparam int          DEPTH = 8;
    localparam int          SPAN  = 4;
    localparam logic [25:0] BASE  = 26'h40;
    localparam logic [25:0] LAST  = BASE + 26'd15;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1, enable = 1'b0, restart = 1'b0, sample_tick = 1'b0;
    logic [15:0] sample_out;
    logic        sample_valid, underrun, done;
    logic [3:0]  fifo_level;

    sdram_audio_fetch_if bus();

    sdram_audio_fetch #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE), .SPAN_LOG2(SPAN)) dut (
        .clk50(clk50), .reset(reset), .enable(enable), .restart(restart), .bus(bus),
        .sample_tick(sample_tick), .sample_out(sample_out), .sample_valid(sample_valid),
        .underrun(underrun), .fifo_level(fifo_level), .done(done)
    );

    always #5 clk50 = ~clk50;

    int          n_checks = 0, n_fail = 0;
    logic [15:0] salt;
    logic [15:0] m_fifo[$];
    logic [15:0] exp_q[$];
    logic [25:0] m_addr;
    bit          m_discard, m_underrun, m_done;
    logic [15:0] m_last;
    int          req_cycles, cur_lat, lat_fixed;
    bit          spur_en, tick_on_ack, ack_seen;
    bit          prev_read, wrap_seen;
    logic [25:0] prev_addr, last_req;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] word(input logic [25:0] a);
        return (a[15:0] * 16'h9e37) ^ salt;
    endfunction

    // One cycle: play the arbiter, drive inputs, advance the model for the coming edge
    task automatic step(input bit tick, input bit rst);
        bit in_req, ack, t;
        in_req = bus.read_out;
        ack    = 1'b0;
        t      = tick;
        if (in_req) begin
            if (req_cycles == 0) cur_lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 5));
            req_cycles++;
            if (req_cycles >= cur_lat) ack = 1'b1;
        end else begin
            req_cycles = 0;
        end
        if (tick_on_ack && ack) begin
            t           = 1'b1;
            enable      = 1'b0;
            tick_on_ack = 1'b0;
        end
        ack_seen        = ack;
        bus.ack_in      = ack || (!in_req && spur_en && ($urandom_range(0, 7) == 0));
        bus.readdata_in = ack ? word(m_addr) : 16'($urandom);
        restart         = rst;
        sample_tick     = t;

        if (t && !rst) begin
            if (m_fifo.size() > 0) exp_q.push_back(m_fifo.pop_front());
            else m_underrun = 1'b1;
        end
        if (ack) begin
            if (rst || m_discard) begin
                m_addr    = BASE;
                m_discard = 1'b0;
            end else begin
                m_fifo.push_back(word(m_addr));
                if (m_addr == LAST) begin
                    m_addr = BASE;
`ifndef AUDIO_FETCH_LOOP_EN
                    m_done = 1'b1;
`endif
                end else begin
                    m_addr = m_addr + 26'd1;
                end
            end
        end
        if (rst) begin
            m_fifo.delete();
            m_underrun = 1'b0;
            m_done     = 1'b0;
            if (in_req && !ack) m_discard = 1'b1;
            else if (!ack)      m_addr    = BASE;
        end
        @(negedge clk50);
    endtask

    always @(posedge clk50) begin
        #2;
        if (!reset) begin
            if (sample_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0h, expected no sample at %0t", sample_out, $time);
                end else begin
                    m_last = exp_q.pop_front();
                    check("sample_data", 32'(sample_out), 32'(m_last));
                end
            end else begin
                check("sample_hold", 32'(sample_out), 32'(m_last));
            end
            check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
            check("underrun", 32'(underrun), 32'(m_underrun));
            check("done", 32'(done), 32'(m_done));
            check("read_after_done", 32'(bus.read_out & m_done), 32'd0);
            if (bus.read_out && !prev_read) begin
                check("req_addr", 32'(bus.addr_out), 32'(m_addr));
                if (last_req == LAST && bus.addr_out == BASE) wrap_seen = 1'b1;
                last_req = bus.addr_out;
            end
            if (bus.read_out && prev_read) check("addr_stable", 32'(bus.addr_out), 32'(prev_addr));
            if (prev_read && bus.ack_in)   check("gap_low", 32'(bus.read_out), 32'd0);
        end
        prev_read = bus.read_out;
        prev_addr = bus.addr_out;
    end

    initial begin
        bit hit, got;
        salt            = 16'($urandom);
        bus.ack_in      = 1'b0;
        bus.readdata_in = 16'h0;
        m_addr = BASE; m_last = 16'h0; m_discard = 0; m_underrun = 0; m_done = 0;
        lat_fixed = 3; req_cycles = 0; cur_lat = 3; spur_en = 0; tick_on_ack = 0;
        prev_read = 0; prev_addr = BASE; last_req = BASE; wrap_seen = 0;

        repeat (3) @(negedge clk50);
        check("rst_read", 32'(bus.read_out), 32'd0);
        check("rst_addr", 32'(bus.addr_out), 32'(BASE));
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Fill from reset with a fixed 3-cycle ack latency
        enable = 1'b1;
        step(0, 0);
        check("first_req", 32'(bus.read_out), 32'd1);
        check("first_addr", 32'(bus.addr_out), 32'(BASE));
        repeat (60) step(0, 0);
        check("fill_level", 32'(fifo_level), 32'd8);
        check("fill_stop", 32'(bus.read_out), 32'd0);

        // Ticks every 20 cycles from a full FIFO, each followed by a refill
        for (int i = 0; i < 100; i++) begin
            step(i % 20 == 0, 0);
            if (i % 20 == 19) check("refill", 32'(fifo_level), 32'd8);
        end

        // Same-cycle tick and ack at level 4
        enable = 1'b0;
        repeat (10) step(0, 0);
        for (int i = 0; i < 4; i++) begin step(1, 0); step(0, 0); end
        check("lvl4", 32'(fifo_level), 32'd4);
        enable = 1'b1; tick_on_ack = 1'b1; got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            step(0, 0);
            got = ack_seen;
        end
        check("tick_ack_seen", 32'(got), 32'd1);
        check("tick_ack_level", 32'(fifo_level), 32'd4);

        // Drain, underrun on an empty tick, restart clears it
        repeat (3) step(0, 0);
        for (int i = 0; i < 4; i++) begin step(1, 0); step(0, 0); end
        step(1, 0);
        check("underrun_set", 32'(underrun), 32'd1);
        check("underrun_no_valid", 32'(sample_valid), 32'd0);
        check("underrun_hold", 32'(sample_out), 32'(m_last));
        step(0, 1);
        check("underrun_clear", 32'(underrun), 32'd0);

        // Restart while reading word 5; ack two cycles later is dropped
        enable = 1'b1; hit = 1'b0;
        for (int i = 0; i < 80 && !hit; i++) begin
            if (bus.read_out && bus.addr_out == BASE + 26'd5) begin
                step(0, 1);
                hit = 1'b1;
            end else begin
                step(0, 0);
            end
        end
        check("restart_hit", 32'(hit), 32'd1);
        check("restart_flush", 32'(fifo_level), 32'd0);
        step(0, 0); step(0, 0);
        check("discard_ack", 32'(ack_seen), 32'd1);
        check("discard_level", 32'(fifo_level), 32'd0);
        check("discard_addr", 32'(bus.addr_out), 32'(BASE));
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(0, 0);
            got = bus.read_out;
        end
        check("restart_next_req", 32'(got), 32'd1);
        check("restart_next_addr", 32'(bus.addr_out), 32'(BASE));

        // Walk past the last word of the region
        wrap_seen = 1'b0;
        for (int i = 0; i < 250; i++) step(i % 6 == 0, 0);
`ifdef AUDIO_FETCH_LOOP_EN
        check("wrap_seen", 32'(wrap_seen), 32'd1);
`else
        check("done_set", 32'(done), 32'd1);
        check("done_idle", 32'(bus.read_out), 32'd0);
`endif

        // Randomised traffic: ticks, restarts, enable toggles, latencies, stray acks
        step(0, 1);
        lat_fixed = 0; spur_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            step($urandom_range(0, 4) == 0, $urandom_range(0, 119) == 0);
        end
        enable = 1'b0; spur_en = 1'b0;
        repeat (12) step(0, 0);
        check("exp_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
